// File: rtl/synch_fifo.sv
// synch_fifo: single-clock FIFO with registered read data and full/empty flags.
// Define SYNCH_FIFO_ERR_EN to add registered overflow/underflow pulse outputs.
module synch_fifo #(
  parameter int data_width = 25,
  parameter int addr_width = 3,
  parameter int depth      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out,
  output logic                  empty,
  output logic                  full
`ifdef SYNCH_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic [data_width-1:0] data_out_q, data_out_d;
  logic                  wr_acc, rd_acc;
  assign empty    = count_q == '0;
  assign full     = count_q == (addr_width+1)'(depth);
  assign data_out = data_out_q;
  // A write while full is legal only because the same-cycle read frees a slot.
  always_comb begin
    wr_acc     = wr_en & (~full | rd_en);
    rd_acc     = rd_en & ~empty;
    wr_ptr_d   = wr_acc ? wr_ptr_q + addr_width'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + addr_width'(1) : rd_ptr_q;
    data_out_d = rd_acc ? mem[rd_ptr_q] : data_out_q;
    count_d    = (wr_acc & ~rd_acc) ? count_q + (addr_width+1)'(1) :
                 (rd_acc & ~wr_acc) ? count_q - (addr_width+1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end
`ifdef SYNCH_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & empty;
    end
  end
`endif
endmodule

// File: tb/tb_synch_fifo.sv
// tb_synch_fifo: directed scoreboard bench for synch_fifo.
module tb_synch_fifo;
  logic        clk = 1'b1;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [24:0] data_in = '0;
  logic [24:0] data_out;
  logic        empty, full;
  int          cmps = 0;
  int          errs = 0;
  logic [24:0] q[$];
  logic [24:0] dout_m = '0;
`ifdef SYNCH_FIFO_ERR_EN
  logic overflow, underflow;
`endif

  synch_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
`ifdef SYNCH_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input int d);
    logic wacc, racc, was_empty;
    was_empty = q.size() == 0;
    wacc = w && (q.size() != 8 || r);
    racc = r && !was_empty;
    wr_en = w;
    rd_en = r;
    data_in = 25'(d);
    @(posedge clk);
    #1;
    if (racc) dout_m = q.pop_front();
    if (wacc) q.push_back(25'(d));
    chk("data_out", {7'b0, data_out}, {7'b0, dout_m});
    chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("full", {31'b0, full}, {31'b0, q.size() == 8});
`ifdef SYNCH_FIFO_ERR_EN
    chk("overflow", {31'b0, overflow}, {31'b0, w && !wacc});
    chk("underflow", {31'b0, underflow}, {31'b0, r && was_empty});
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #5 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    #1;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_dout", {7'b0, data_out}, 32'd0);
    step(1, 0, 1);
    step(1, 1, 2);
    chk("pop_first", {7'b0, data_out}, 32'd1);
    for (int i = 1; i <= 7; i++) step(1, 0, i * 10);
    chk("full_after_70", {31'b0, full}, 32'd1);
    for (int i = 8; i <= 13; i++) step(1, 0, i * 10);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("drain_last", {7'b0, data_out}, 32'd70);
    step(0, 1, 0);
    chk("extra_pop_hold", {7'b0, data_out}, 32'd70);
    for (int i = 0; i < 3; i++) step(1, 0, 200 + i);
    for (int i = 3; i < 23; i++) step(1, 1, 200 + i);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("wrap_last", {7'b0, data_out}, 32'd222);
    for (int i = 0; i < 8; i++) step(1, 0, 300 + i);
    step(1, 1, 140);
    chk("full_rw_oldest", {7'b0, data_out}, 32'd300);
    chk("full_rw_full", {31'b0, full}, 32'd1);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("full_rw_140_last", {7'b0, data_out}, 32'd140);
    for (int i = 0; i < 4; i++) step(1, 0, 400 + i);
    step(0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    dout_m = '0;
    chk("midrst_empty", {31'b0, empty}, 32'd1);
    chk("midrst_dout", {7'b0, data_out}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 500);
    step(0, 1, 0);
    chk("post_rst", {7'b0, data_out}, 32'd500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
